// File: rtl/lbm_bram_stream_reader.sv
// Streams one lattice frame from the distribution BRAMs out over AXI4-Stream, one pixel per beat.
// Reads are credit-limited so that in-flight reads plus buffered beats never exceed the output FIFO.
module lbm_bram_stream_reader #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_DIRS     = 9,
  parameter int DEPTH        = 2500,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                               m00_axis_aclk,
  input  logic                               m00_axis_aresetn,
  input  logic                               start,
  input  logic                               loop,
  output logic                               busy,
  output logic                               done,
  output logic [15:0]                        frame_count,
  output logic                               rd_en,
  output logic [ADDR_WIDTH-1:0]              rd_addr,
  input  logic [NUM_DIRS*DATA_WIDTH-1:0]     rd_data,
  input  logic                               m00_axis_tready,
  output logic                               m00_axis_tvalid,
  output logic [NUM_DIRS*DATA_WIDTH-1:0]     m00_axis_tdata,
  output logic [NUM_DIRS*DATA_WIDTH/8-1:0]   m00_axis_tstrb,
  output logic                               m00_axis_tlast
);
  localparam int PW = NUM_DIRS*DATA_WIDTH;
  localparam int FD = READ_LATENCY + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH-1);
  localparam logic [2:0]            FD_C      = 3'(FD);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

  state_e                     state_q;
  logic                       rd_en_q, busy_q, done_q;
  logic [ADDR_WIDTH-1:0]      rd_addr_q, nxt_addr_q;
  logic [15:0]                frame_cnt_q;
  logic [2:0]                 cred_q;
  logic [READ_LATENCY-1:0]    vld_pipe_q, last_pipe_q;
  logic [FD-1:0][PW-1:0]      mem_q;
  logic [FD-1:0]              mem_last_q;
  logic [1:0]                 wr_ptr_q, rd_ptr_q;
  logic [2:0]                 occ_q;

  logic pop, last_pop, push, at_end, can_issue, issue, flush;

  function automatic logic [1:0] inc_ptr(input logic [1:0] p);
    return (p == 2'(FD-1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign m00_axis_tvalid = (occ_q != 3'd0);
  assign m00_axis_tdata  = mem_q[rd_ptr_q];
  assign m00_axis_tlast  = m00_axis_tvalid & mem_last_q[rd_ptr_q];
  assign m00_axis_tstrb  = '1;
  assign rd_en           = rd_en_q;
  assign rd_addr         = rd_addr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign frame_count     = frame_cnt_q;

  assign pop       = m00_axis_tvalid & m00_axis_tready;
  assign last_pop  = pop & mem_last_q[rd_ptr_q];
  assign push      = vld_pipe_q[READ_LATENCY-1];
  assign at_end    = (nxt_addr_q == LAST_ADDR);
  assign can_issue = (cred_q - {2'b0, pop}) < FD_C;
  // A non-looping frame ends here; anything prefetched for a next frame is dropped.
  assign flush     = (state_q == DRAIN) & last_pop & ~loop;

  // While draining with loop high, the next frame is prefetched so looped frames
  // stay back-to-back; its final read is held back until the loop decision is taken.
  always_comb begin
    issue = 1'b0;
    case (state_q)
      IDLE:    issue = start;
      FETCH:   issue = can_issue;
      DRAIN:   issue = can_issue & loop & (last_pop | ~at_end);
      default: issue = 1'b0;
    endcase
  end

  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state_q     <= IDLE;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      nxt_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      rd_en_q <= issue;
      done_q  <= flush;
      if (issue) begin
        rd_addr_q  <= nxt_addr_q;
        nxt_addr_q <= at_end ? '0 : nxt_addr_q + 1'b1;
      end
      if (flush) nxt_addr_q <= '0;
      if (last_pop) frame_cnt_q <= frame_cnt_q + 16'd1;
      case (state_q)
        IDLE: if (start) begin
          state_q <= at_end ? DRAIN : FETCH;
          busy_q  <= 1'b1;
        end
        FETCH: if (issue && at_end) state_q <= DRAIN;
        DRAIN: if (last_pop) begin
          if (!loop) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= (issue && at_end) ? DRAIN : FETCH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // cred_q counts reads issued (including the one on rd_en now) that are not yet popped.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      cred_q      <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      mem_q       <= '0;
      mem_last_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
    end else begin
      cred_q <= flush ? 3'd0 : cred_q - {2'b0, pop} + {2'b0, issue};
      vld_pipe_q[0]  <= rd_en_q & ~flush;
      last_pipe_q[0] <= (rd_addr_q == LAST_ADDR);
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_pipe_q[i]  <= vld_pipe_q[i-1] & ~flush;
        last_pipe_q[i] <= last_pipe_q[i-1];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push) begin
          mem_q[wr_ptr_q]      <= rd_data;
          mem_last_q[wr_ptr_q] <= last_pipe_q[READ_LATENCY-1];
          wr_ptr_q             <= inc_ptr(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= inc_ptr(rd_ptr_q);
        occ_q <= occ_q + {2'b0, push} - {2'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_lbm_bram_stream_reader.sv
// Bench for lbm_bram_stream_reader: default-size instance driven by scenarios with random
// backpressure, plus a wide, deep-latency instance checked for packing and first-beat timing.
module tb_lbm_bram_stream_reader;
  localparam int DW = 16, ND = 9, DEPTH = 2500, AW = 12, RL = 1, FD = RL + 2, PW = ND*DW;
  localparam int S_DW = 32, S_ND = 19, S_DEPTH = 16, S_AW = 4, S_RL = 2, S_PW = S_ND*S_DW;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start, loop, busy, done, rd_en, tready, tvalid, tlast;
  logic [15:0] frame_count;
  logic [AW-1:0] rd_addr;
  logic [PW-1:0] rd_data, tdata;
  logic [PW/8-1:0] tstrb;

  logic s_start, s_loop, s_busy, s_done, s_rd_en, s_tready, s_tvalid, s_tlast;
  logic [15:0] s_frame_count;
  logic [S_AW-1:0] s_rd_addr;
  logic [S_PW-1:0] s_rd_data, s_tdata, s_stage;
  logic [S_PW/8-1:0] s_tstrb, s_ones;

  lbm_bram_stream_reader #(.DATA_WIDTH(DW), .NUM_DIRS(ND), .DEPTH(DEPTH), .ADDR_WIDTH(AW),
    .READ_LATENCY(RL)) u_dut (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start), .loop(loop), .busy(busy),
    .done(done), .frame_count(frame_count), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .m00_axis_tready(tready), .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata),
    .m00_axis_tstrb(tstrb), .m00_axis_tlast(tlast));

  lbm_bram_stream_reader #(.DATA_WIDTH(S_DW), .NUM_DIRS(S_ND), .DEPTH(S_DEPTH), .ADDR_WIDTH(S_AW),
    .READ_LATENCY(S_RL)) u_small (
    .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(s_start), .loop(s_loop), .busy(s_busy),
    .done(s_done), .frame_count(s_frame_count), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .rd_data(s_rd_data), .m00_axis_tready(s_tready), .m00_axis_tvalid(s_tvalid),
    .m00_axis_tdata(s_tdata), .m00_axis_tstrb(s_tstrb), .m00_axis_tlast(s_tlast));

  // Frame contents: direction 0 carries the pixel address itself.
  function automatic logic [PW-1:0] word(input int a);
    logic [PW-1:0] w;
    for (int k = 0; k < ND; k++) w[k*DW +: DW] = 16'(a*(k+1)) ^ 16'(k*16'h1357);
    return w;
  endfunction
  function automatic logic [S_PW-1:0] sword(input int a);
    logic [S_PW-1:0] w;
    for (int k = 0; k < S_ND; k++) w[k*S_DW +: S_DW] = {8'(k), 8'hC3, 16'(a*7 + k)};
    return w;
  endfunction

  // BRAM models; off-cycle data is junk so a mistimed capture shows up.
  always @(posedge clk) rd_data <= rd_en ? word(int'(rd_addr)) : {ND{16'hDEAD}};
  always @(posedge clk) begin
    s_stage   <= s_rd_en ? sword(int'(s_rd_addr)) : {S_ND{32'hDEADBEEF}};
    s_rd_data <= s_stage;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [639:0] got, input logic [639:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int rdy_mode = 0;   // 0: always ready, 1: random, 2: stalled
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       tready = 1'($urandom_range(0, 1));
      2:       tready = 1'b0;
      default: tready = 1'b1;
    endcase
  end

  // Reference model: the expected stream is simply addresses 0..DEPTH-1 repeated.
  int exp_addr, exp_frames, beats, first_hs, last_hs, pend_done, outc, rd_cnt;
  logic hold_v, hold_l;
  logic [PW-1:0] hold_d;

  task automatic clear_model();
    exp_addr = 0; exp_frames = 0; pend_done = -1; outc = 0; hold_v = 1'b0;
  endtask
  task automatic clear_phase();
    beats = 0; first_hs = -1; last_hs = -1; rd_cnt = 0;
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("frame_count", frame_count, 16'(exp_frames));
    chk("done_pulse", done, (pend_done >= 0) && (cyc == pend_done + 1));
    if (done) begin outc = 0; pend_done = -1; end
    if (rd_en) begin
      rd_cnt++;
      chk("outstanding_le_fd", (outc + 1) <= FD, 1);
      outc++;
    end
    if (hold_v) begin
      chk("stall_tvalid", tvalid, 1);
      chk("stall_tdata", tdata, hold_d);
      chk("stall_tlast", tlast, hold_l);
    end
    hold_v = tvalid & ~tready; hold_d = tdata; hold_l = tlast;
    if (tvalid && tready) begin
      chk("beat_data", tdata, word(exp_addr));
      chk("beat_last", tlast, exp_addr == DEPTH-1);
      outc--; beats++;
      if (first_hs < 0) first_hs = cyc;
      last_hs = cyc;
      if (exp_addr == DEPTH-1) begin
        exp_frames = (exp_frames + 1) % 65536;
        exp_addr = 0;
        if (!loop) pend_done = cyc;
      end else exp_addr++;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin @(negedge clk); n++; end
    chk({tag, "_done_seen"}, done, 1);
    chk({tag, "_busy_low_at_done"}, busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_tlast"}, tlast, 0);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_frame_count"}, frame_count, 0);
  endtask

  initial begin
    int n, s_exp;
    start = 0; loop = 0; s_start = 0; s_loop = 0; s_tready = 1; s_ones = '1;
    clear_model(); clear_phase();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs("rst0");
    rst_n = 1'b1;

    // A: always ready, single frame, latency and contiguity.
    clear_phase();
    pulse_start();
    @(negedge clk);
    chk("A_rd_en_c1", rd_en, 1); chk("A_rd_addr_c1", rd_addr, 0); chk("A_busy_c1", busy, 1);
    @(negedge clk); chk("A_tvalid_c2", tvalid, 0);
    @(negedge clk); chk("A_tvalid_c3", tvalid, 1); chk("A_tstrb", tstrb, 18'h3FFFF);
    wait_done("A", 3000);
    chk("A_beats", beats, DEPTH); chk("A_span", last_hs - first_hs, DEPTH-1);
    chk("A_frame_count", frame_count, 1);

    // B: random backpressure.
    clear_phase(); rdy_mode = 1;
    pulse_start();
    wait_done("B", 8000);
    chk("B_beats", beats, DEPTH);
    rdy_mode = 0;

    // C: stalled after start, then released.
    @(posedge clk); #1 rdy_mode = 2;
    @(posedge clk);
    clear_phase();
    pulse_start();
    repeat (100) @(negedge clk);
    chk("C_reads_while_stalled", rd_cnt, FD); chk("C_tvalid_stalled", tvalid, 1);
    rdy_mode = 0;
    wait_done("C", 3000);
    chk("C_beats", beats, DEPTH); chk("C_span", last_hs - first_hs, DEPTH-1);

    // D: three looped frames, loop released during the third.
    clear_phase();
    @(posedge clk); #1 loop = 1'b1;
    pulse_start();
    n = 0;
    while (exp_frames < 5 && n < 6000) begin @(negedge clk); n++; end
    chk("D_two_frames_looped", exp_frames, 5);
    @(posedge clk); #1 loop = 1'b0;
    wait_done("D", 3000);
    chk("D_beats", beats, 3*DEPTH); chk("D_span", last_hs - first_hs, 3*DEPTH-1);
    chk("D_frame_count", frame_count, 6);

    // E: reset mid-frame, then restream.
    clear_phase(); rdy_mode = 1;
    pulse_start();
    n = 0;
    while (beats < 1200 && n < 5000) begin @(negedge clk); n++; end
    chk("E_reached_1200", beats, 1200);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check_reset_outputs("E_rst");
    clear_model(); rdy_mode = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    clear_phase();
    pulse_start();
    wait_done("E2", 3000);
    chk("E2_beats", beats, DEPTH); chk("E2_frame_count", frame_count, 1);

    // S: wide packing, READ_LATENCY=2.
    @(posedge clk); #1 s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin @(negedge clk); chk("S_tvalid_early", s_tvalid, 0); end
    @(negedge clk); chk("S_tvalid_c4", s_tvalid, 1); chk("S_tstrb", s_tstrb, s_ones);
    n = 0; s_exp = 0;
    while (s_exp < S_DEPTH && n < 60) begin
      if (s_tvalid) begin
        chk("S_beat_data", s_tdata, sword(s_exp));
        chk("S_beat_last", s_tlast, s_exp == S_DEPTH-1);
        s_exp++;
      end
      n++;
      @(negedge clk);
    end
    chk("S_beats", s_exp, S_DEPTH);
    chk("S_done", s_done, 1); chk("S_frame_count", s_frame_count, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/lbm_bram_stream_reader.md
Name: lbm_bram_stream_reader

Overview:
- Streams one full lattice frame from the solver's distribution BRAMs out over AXI4-Stream, one pixel per beat, with all NUM_DIRS direction values packed side by side.
- Successor to the fixed 9×16-bit, 2500-pixel readout. It generalises width, direction count and depth, and models BRAM read latency with credit-based prefetch.
- Adds proper tvalid/tready backpressure, start/busy/done control and an optional continuous (loop) mode.
- Sits between the LBM solver's BRAM banks and the DMA-facing AXIS master port.

Parameters:
- DATA_WIDTH, 16, bits per direction value.
- NUM_DIRS, 9, number of direction channels packed per beat.
- DEPTH, 2500, pixels per frame; addresses 0..DEPTH-1.
- ADDR_WIDTH, 12, BRAM address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- READ_LATENCY, 1, BRAM rd_en-to-rd_data latency in cycles; legal values 1 or 2.

Ports:
- m00_axis_aclk  in  1  clock.
- m00_axis_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to stream one frame; ignored while busy.
- loop  in  1  sampled at the last-beat handshake; if 1, the next frame starts immediately.
- busy  out  1  high from start acceptance until the final beat handshake of a non-looping frame.
- done  out  1  one-cycle pulse after the final beat handshake of a non-looping frame.
- frame_count  out  16  frames completed since reset; wraps at 65535.
- rd_en  out  1  BRAM read enable.
- rd_addr  out  ADDR_WIDTH  BRAM read address.
- rd_data  in  NUM_DIRS*DATA_WIDTH  BRAM data, valid READ_LATENCY cycles after rd_en.
- m00_axis_tready  in  1  downstream ready.
- m00_axis_tvalid  out  1  beat valid.
- m00_axis_tdata  out  NUM_DIRS*DATA_WIDTH  packed pixel; direction k occupies bits [k*DATA_WIDTH +: DATA_WIDTH], with k=0 at the LSBs.
- m00_axis_tstrb  out  NUM_DIRS*DATA_WIDTH/8  all ones.
- m00_axis_tlast  out  1  high on beat for pixel DEPTH-1 only.

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_en=0; rd_addr=0; tvalid=0; tlast=0; tdata=0; busy=0; done=0; frame_count=0; FIFO and all counters cleared.
- Reset mid-frame aborts the frame. No partial tlast is emitted, and frame_count is not incremented.
- States:
  - IDLE: wait for start.
  - FETCH: issue reads.
  - DRAIN: all DEPTH reads issued; wait for the last handshake.
- Transitions:
  - IDLE→FETCH on start=1.
  - FETCH→DRAIN when the read for address DEPTH-1 is issued.
  - DRAIN→IDLE on handshake of the tlast beat with loop=0 (done pulses the next cycle).
  - DRAIN→FETCH on that handshake with loop=1 (rd_addr restarts at 0; no done pulse).
- Prefetch:
  - Output FIFO depth is READ_LATENCY+2.
  - rd_en is issued in FETCH only while reads in flight plus FIFO occupancy is below FIFO depth. A same-cycle pop counts as freeing a slot.
  - rd_addr increments by 1 per issued read, starting at 0 each frame, and never exceeds DEPTH-1.
- Latency: start high in cycle 0 → rd_en=1, rd_addr=0 in cycle 1 → tvalid=1 in cycle 2+READ_LATENCY.
- Throughput: exactly 1 beat/cycle sustained while tready=1, including across looped frame boundaries (no bubble).
- AXIS rules:
  - tvalid does not depend combinationally on tready.
  - Once tvalid=1, tdata and tlast are held stable until the handshake (tvalid & tready).
  - Beats leave in address order 0..DEPTH-1 with no drops or duplicates.
- Backpressure: with tready held low, at most FIFO depth reads are outstanding or buffered. After that, rd_en stays low until pops occur.
- Counting: frame_count increments on every tlast handshake, including looped frames.
- Simultaneous events:
  - start during busy is ignored.
  - start coinciding with the done cycle is accepted (IDLE is reached that cycle).
- Edge case: DEPTH=1 makes the first beat also the tlast beat.

Test Plan:
- Defaults, tready=1, start pulse → tvalid in cycle 3; 2500 consecutive beats with tdata[15:0]=dir0 of addresses 0..2499; tlast only on beat 2500; done pulse one cycle later; frame_count=1.
- Random tready (50% duty) → beat sequence identical to the tready=1 run; tdata is stable while stalled; rd_en never has more than READ_LATENCY+2 reads outstanding or buffered.
- tready=0 for 100 cycles after start → rd_en issues exactly 3 reads (READ_LATENCY=1) then idles; on release, beats for addresses 0,1,2,... arrive with no gap.
- loop=1 over 3 frames, tready=1 → 7500 contiguous beats, tlast on beats 2500, 5000 and 7500; no done pulse while looping; frame_count=3; loop=0 on the third tlast handshake → done pulse, busy=0.
- Reset asserted at beat 1200 → all outputs go to their reset values immediately; a subsequent start restreams from address 0; frame_count=0.
- NUM_DIRS=19, DATA_WIDTH=32, READ_LATENCY=2, DEPTH=16 → 608-bit tdata with correct per-direction packing; tstrb=76 ones; first tvalid in cycle 4.
